// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo deframer: default block geometry and FSM states.
package turbo_pkg;

  localparam int DEF_K_LONG   = 6;
  localparam int DEF_K_SHORT  = 4;
  localparam int DEF_TAIL_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TAIL
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rsc_check.sv
// RSC re-encoder that regenerates parity-1 from the systematic stream and flags zk mismatches.
module rsc_check (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic xk,
  input  logic zk,
  output logic mismatch
);

  logic s1, s2, s3;
  logic s1_e, s2_e, s3_e;
  logic a, p;

  // clear zeroes the state seen by the current bit, so bit 0 encodes from the all-zero state.
  always_comb begin
    s1_e     = clear ? 1'b0 : s1;
    s2_e     = clear ? 1'b0 : s2;
    s3_e     = clear ? 1'b0 : s3;
    a        = xk ^ s2_e ^ s3_e;
    p        = a ^ s1_e ^ s3_e;
    mismatch = enable & (zk ^ p);
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else if (enable) begin
      s1 <= a;
      s2 <= s1_e;
      s3 <= s2_e;
    end
  end

endmodule

// File: rtl/turbo_deframer.sv
// Turbo block deframer: splits data/tail cycles, checks parity-1 and reports per-block status.
module turbo_deframer
  import turbo_pkg::*;
#(
  parameter int K_LONG   = DEF_K_LONG,
  parameter int K_SHORT  = DEF_K_SHORT,
  parameter int TAIL_LEN = DEF_TAIL_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  look_now,
  input  logic                  length_in,
  input  logic                  xk,
  input  logic                  zk,
  input  logic                  zkp,
  output logic                  dout,
  output logic                  dout_zkp,
  output logic                  dout_valid,
  output logic                  dout_first,
  output logic                  dout_last,
  output logic [3*TAIL_LEN-1:0] tail_bits,
  output logic                  blk_done,
  output logic [3:0]            par_err_cnt,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(max_int(K_LONG, K_SHORT) + TAIL_LEN + 1);
  localparam int TW    = 3 * TAIL_LEN;

  localparam logic [CNT_W-1:0] K_LONG_LAST  = CNT_W'(K_LONG - 1);
  localparam logic [CNT_W-1:0] K_SHORT_LAST = CNT_W'(K_SHORT - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST    = CNT_W'(TAIL_LEN - 1);
  localparam bit LONG_SINGLE  = (K_LONG == 1);
  localparam bit SHORT_SINGLE = (K_SHORT == 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             len_q;
  logic [CNT_W-1:0] k_last;
  logic             start_single;

  logic data_cyc, bit0, last_data, tail_cyc, last_tail, abort;
  logic mismatch;

  logic [3:0]    err_cnt;
  logic [TW-1:0] tail_sh, tail_nxt;

  assign k_last       = len_q ? K_LONG_LAST : K_SHORT_LAST;
  assign start_single = length_in ? LONG_SINGLE : SHORT_SINGLE;
  assign tail_nxt     = TW'({tail_sh, xk, zk, zkp});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // IDLE with look_now high is itself data bit 0, which is what makes back-to-back blocks gapless.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    data_cyc  = 1'b0;
    bit0      = 1'b0;
    last_data = 1'b0;
    tail_cyc  = 1'b0;
    last_tail = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (look_now) begin
          data_cyc = 1'b1;
          bit0     = 1'b1;
          if (start_single) begin
            last_data = 1'b1;
            state_nxt = ST_TAIL;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_DATA;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (!look_now) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          data_cyc = 1'b1;
          if (cnt == k_last) begin
            last_data = 1'b1;
            state_nxt = ST_TAIL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_TAIL: begin
        if (!look_now) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          tail_cyc = 1'b1;
          if (cnt == TAIL_LAST) begin
            last_tail = 1'b1;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  rsc_check u_rsc_check (
    .clk      (clk),
    .rst      (rst),
    .clear    (bit0),
    .enable   (data_cyc),
    .xk       (xk),
    .zk       (zk),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dout        <= 1'b0;
      dout_zkp    <= 1'b0;
      dout_valid  <= 1'b0;
      dout_first  <= 1'b0;
      dout_last   <= 1'b0;
      blk_done    <= 1'b0;
      frame_err   <= 1'b0;
      tail_bits   <= '0;
      par_err_cnt <= '0;
      len_q       <= 1'b0;
      err_cnt     <= '0;
      tail_sh     <= '0;
    end else begin
      dout       <= data_cyc & xk;
      dout_zkp   <= data_cyc & zkp;
      dout_valid <= data_cyc;
      dout_first <= bit0;
      dout_last  <= last_data;
      blk_done   <= last_tail;
      frame_err  <= abort;
      if (bit0) len_q <= length_in;
      // The running count restarts at bit 0; the published count only moves at block completion.
      if (data_cyc) begin
        if (bit0)
          err_cnt <= {3'b000, mismatch};
        else if (mismatch && err_cnt != 4'hF)
          err_cnt <= err_cnt + 4'd1;
      end
      if (tail_cyc) tail_sh <= tail_nxt;
      if (last_tail) begin
        tail_bits   <= tail_nxt;
        par_err_cnt <= err_cnt;
      end
    end
  end

endmodule
